aes_shift_rows: RTL and testbench

AES ShiftRows / InvShiftRows byte-permutation stage for the HEA datapath. It is a single registered pipeline stage with a valid/ready handshake. The permutation direction is fixed at elaboration by the OP parameter: encrypt instance uses ShiftRows, decrypt instance uses InvShiftRows. The stage sits between SubBytes and MixColumns in the encrypt round, and between InvShiftRows-consuming stages in the decrypt round.

---
 rtl/aes_shift_rows.sv | 60 ++++++
 tb/tb_aes_shift_rows.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/aes_shift_rows.sv
// AES ShiftRows / InvShiftRows stage: a registered byte permutation with a valid/ready handshake.
// OP selects the direction at elaboration: 1 = ShiftRows (encrypt), 0 = InvShiftRows (decrypt).
module aes_shift_rows #(
    parameter logic OP = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] s_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] s_o
);

    logic         valid_q, valid_d;
    logic [127:0] s_q, s_d;
    logic [127:0] perm;
    logic         accept;

    // Byte k = 4*c + r sits at s[127-8k -: 8]. Each output byte takes the same row
    // from a source column rotated by r (left for OP=1, right for OP=0).
    always_comb begin
        perm = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                perm[127 - 8*(4*c + r) -: 8] =
                    s_i[127 - 8*(4*(OP ? ((c + r) % 4) : ((c + 4 - r) % 4)) + r) -: 8];
            end
        end
    end

    assign ready_o = !valid_q || ready_i;
    assign accept  = valid_i && ready_o;

    always_comb begin
        valid_d = valid_q;
        s_d     = s_q;
        if (accept) begin
            valid_d = 1'b1;
            s_d     = perm;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            s_q     <= '0;
        end else begin
            valid_q <= valid_d;
            s_q     <= s_d;
        end
    end

    assign valid_o = valid_q;
    assign s_o     = s_q;

endmodule

// File: tb/tb_aes_shift_rows.sv
// Bench for aes_shift_rows: encrypt and decrypt instances, directed steps, queue scoreboard.
module tb_aes_shift_rows;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         e_valid_i, e_ready_o, e_valid_o, e_ready_i;
    logic [127:0] e_s_i, e_s_o;
    logic         d_valid_i, d_ready_o, d_valid_o, d_ready_i;
    logic [127:0] d_s_i, d_s_o;

    int errors = 0;
    int checks = 0;

    logic [127:0] q_e[$];
    logic [127:0] q_d[$];

    localparam logic [127:0] VEC1     = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] VEC1_ENC = 128'h00050A0F_04090E03_080D0207_0C01060B;
    localparam logic [127:0] VEC1_DEC = 128'h000D0A07_04010E0B_0805020F_0C090603;
    localparam logic [127:0] FIPS_IN  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

    always #5 clk = ~clk;

    aes_shift_rows #(.OP(1'b1)) u_enc (
        .clk_i(clk), .rst_ni(rst_n),
        .valid_i(e_valid_i), .ready_o(e_ready_o), .s_i(e_s_i),
        .valid_o(e_valid_o), .ready_i(e_ready_i), .s_o(e_s_o)
    );

    aes_shift_rows #(.OP(1'b0)) u_dec (
        .clk_i(clk), .rst_ni(rst_n),
        .valid_i(d_valid_i), .ready_o(d_ready_o), .s_i(d_s_i),
        .valid_o(d_valid_o), .ready_i(d_ready_i), .s_o(d_s_o)
    );

    // Reference: build the 4x4 byte matrix, rotate each row r by r positions.
    function automatic logic [127:0] ref_perm(input logic [127:0] s, input bit fwd);
        logic [7:0]   m [4][4];
        logic [127:0] o;
        int           src;
        for (int k = 0; k < 16; k++) m[k % 4][k / 4] = s[127 - 8*k -: 8];
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = fwd ? (c + r) % 4 : (c - r + 4) % 4;
                o[127 - 8*(4*c + r) -: 8] = m[r][src];
            end
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score outputs consumed and inputs accepted at this edge, then advance.
    task automatic tick();
        logic [127:0] exp;
        if (!rst_n) begin
            q_e.delete();
            q_d.delete();
        end else begin
            if (e_valid_o && e_ready_i) begin
                if (q_e.size() == 0) chk("enc_sb_underflow", 128'd1, 128'd0);
                else begin exp = q_e.pop_front(); chk("enc_sb", e_s_o, exp); end
            end
            if (d_valid_o && d_ready_i) begin
                if (q_d.size() == 0) chk("dec_sb_underflow", 128'd1, 128'd0);
                else begin exp = q_d.pop_front(); chk("dec_sb", d_s_o, exp); end
            end
            if (e_valid_i && e_ready_o) q_e.push_back(ref_perm(e_s_i, 1'b1));
            if (d_valid_i && d_ready_o) q_d.push_back(ref_perm(d_s_i, 1'b0));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] rnd;
        logic [127:0] nxt;

        rst_n = 1'b0;
        e_valid_i = 1'b0; e_ready_i = 1'b1; e_s_i = '0;
        d_valid_i = 1'b0; d_ready_i = 1'b1; d_s_i = '0;
        tick();
        tick();
        chk("rst_enc_valid", {127'd0, e_valid_o}, 128'd0);
        chk("rst_enc_s", e_s_o, 128'd0);
        chk("rst_enc_ready", {127'd0, e_ready_o}, 128'd1);
        chk("rst_dec_valid", {127'd0, d_valid_o}, 128'd0);

        // Basic vector through both directions
        rst_n = 1'b1;
        e_valid_i = 1'b1; e_s_i = VEC1;
        d_valid_i = 1'b1; d_s_i = VEC1;
        tick();
        chk("enc_vec1_valid", {127'd0, e_valid_o}, 128'd1);
        chk("enc_vec1", e_s_o, VEC1_ENC);
        chk("dec_vec1", d_s_o, VEC1_DEC);

        // FIPS-197 vector, and the inverse returning the original
        e_s_i = FIPS_IN;
        d_s_i = FIPS_OUT;
        tick();
        chk("enc_fips", e_s_o, FIPS_OUT);
        chk("dec_fips_roundtrip", d_s_o, FIPS_IN);

        // Backpressure on the encrypt instance
        d_valid_i = 1'b0;
        nxt = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        e_s_i = nxt;
        e_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_s", e_s_o, FIPS_OUT);
            chk("bp_hold_valid", {127'd0, e_valid_o}, 128'd1);
            chk("bp_ready_low", {127'd0, e_ready_o}, 128'd0);
            e_s_i = ~e_s_i;
        end
        e_s_i = nxt;
        e_ready_i = 1'b1;
        tick();
        chk("bp_release", e_s_o, ref_perm(nxt, 1'b1));

        // Streaming: four back-to-back states, no bubbles
        for (int i = 0; i < 4; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            e_s_i = rnd;
            d_s_i = rnd;
            d_valid_i = 1'b1;
            tick();
            chk("stream_enc_valid", {127'd0, e_valid_o}, 128'd1);
            chk("stream_dec_valid", {127'd0, d_valid_o}, 128'd1);
        end
        e_valid_i = 1'b0;
        d_valid_i = 1'b0;
        tick();
        chk("drain_enc_valid", {127'd0, e_valid_o}, 128'd0);

        // Reset while holding a valid output
        e_valid_i = 1'b1; e_s_i = FIPS_IN; e_ready_i = 1'b0;
        tick();
        chk("pre_rst_valid", {127'd0, e_valid_o}, 128'd1);
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", {127'd0, e_valid_o}, 128'd0);
        chk("midrst_s", e_s_o, 128'd0);
        chk("midrst_ready", {127'd0, e_ready_o}, 128'd1);
        rst_n = 1'b1;
        e_ready_i = 1'b1;
        e_s_i = VEC1;
        tick();
        chk("post_rst_valid", {127'd0, e_valid_o}, 128'd1);
        chk("post_rst_s", e_s_o, VEC1_ENC);
        e_valid_i = 1'b0;
        tick();
        chk("enc_sb_empty", 128'(q_e.size()), 128'd0);
        chk("dec_sb_empty", 128'(q_d.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
